microwave_ctrl: RTL and testbench
=================================

Name: microwave_ctrl

Overview:
Top-level cooking controller for the microwave. It sequences the countdown timer: it shifts keypad digits into the timer, generates the 1 s count enable, gates the magnetron, and handles door, stop and completion events. It sits between the keypad/door inputs and the timer's data/loadn/clrn/en inputs, and consumes the timer's zero flag.

Parameters:
TICK_DIV, 100, clk cycles per 1 s timer tick (must be >= 2)
MAX_DIGITS, 3, max keypad digits accepted per entry (mins, sec_tens, sec_ones)
DONE_CYCLES, 8, cycles the done indication stays high

Ports:
clk  input  1  system clock, rising edge
clrn  input  1  synchronous active-low reset
key_valid  input  1  one-cycle pulse, key_digit valid
key_digit  input  4  BCD digit
start  input  1  one-cycle start/resume pulse
stop  input  1  one-cycle stop/cancel pulse
door_closed  input  1  1 = door closed
timer_zero  input  1  timer zero flag
timer_data  output  4  digit to timer
timer_loadn  output  1  active-low digit load strobe to timer
timer_clrn  output  1  active-low clear to timer
timer_en  output  1  one-cycle count-down enable to timer
mag_on  output  1  magnetron enable
done  output  1  cook-complete indication
digit_cnt  output  2  digits loaded so far
state  output  3  IDLE=0, ENTRY=1, COOK=2, PAUSED=3, DONE=4

Behaviour:
- All outputs registered; response appears on the edge after the input is sampled.
- Reset (clrn=0 at edge): state IDLE, timer_data 0, timer_loadn 1, timer_clrn 0, timer_en 0, mag_on 0, done 0, digit_cnt 0, prescaler 0, done counter 0. timer_clrn returns to 1 on the first edge with clrn=1. Reset mid-cook drops mag_on on that edge.
- Key accept (IDLE or ENTRY): key_valid=1, key_digit<=9, digit_cnt<MAX_DIGITS -> timer_data=key_digit, timer_loadn=0 for exactly one cycle, digit_cnt+1, state ENTRY. Digits >9 or beyond MAX_DIGITS are ignored (no strobe). key_valid ignored in COOK/PAUSED/DONE.
- IDLE: start and stop ignored.
- ENTRY: stop -> IDLE, digit_cnt 0, timer_clrn=0 one cycle. start with door_closed=1 -> COOK. start with door open is ignored. start+key_valid same cycle: start wins, key dropped. start+stop: stop wins.
- COOK: mag_on=1. Prescaler counts 0..TICK_DIV-1; when at TICK_DIV-1, timer_en=1 for one cycle and prescaler wraps to 0. First tick on the TICK_DIV-th COOK cycle after a fresh start.
- COOK exit priority: timer_zero -> DONE; else door_closed=0 -> PAUSED; else stop -> PAUSED. On any exit, mag_on=0 and timer_en=0 on the same edge, so no tick is issued in the exit cycle.
- PAUSED: mag_on 0; prescaler holds its value. start with door_closed=1 -> COOK, prescaler resumes from its held value. stop -> IDLE with timer clear and digit_cnt 0. start+stop: stop wins.
- DONE: done=1 for exactly DONE_CYCLES cycles, then IDLE with timer_clrn=0 for one cycle and digit_cnt 0. stop -> IDLE immediately, with the same clear. key_valid and start are ignored.
- Prescaler resets to 0 on entry to IDLE and on reset.

Test Plan:
1. Reset, then keys 9,3,2 on separate cycles -> three single-cycle timer_loadn=0 pulses with timer_data 9,3,2; digit_cnt=3; state=1. A fourth key 5 produces no strobe.
2. TICK_DIV=4, door closed, start -> state=2, mag_on=1, timer_en pulses on COOK cycles 4, 8, 12.
3. door_closed drops mid-cook -> next edge state=3, mag_on=0, no timer_en. Close the door and pulse start -> state=2; the next tick arrives after the remaining prescaler count, not a full TICK_DIV.
4. timer_zero=1 in COOK -> state=4, mag_on=0, done=1 for exactly 8 cycles, then state=0, one-cycle timer_clrn=0, digit_cnt=0.
5. start in IDLE -> stays 0. key 4'hA -> no strobe. ENTRY + start with door open -> stays 1. start+stop together in ENTRY -> IDLE.
6. clrn=0 during COOK -> next edge state=0, mag_on=0, timer_clrn=0, digit_cnt=0; timer_clrn=1 one cycle after release.

Source files
------------

// File: rtl/microwave_ctrl.sv
// Microwave cooking controller: keypad entry, 1 s tick prescaler,
// magnetron gating and door/stop/complete sequencing for the timer.
module microwave_ctrl #(
  parameter int TICK_DIV    = 100,
  parameter int MAX_DIGITS  = 3,
  parameter int DONE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic [3:0] timer_data,
  output logic       timer_loadn,
  output logic       timer_clrn,
  output logic       timer_en,
  output logic       mag_on,
  output logic       done,
  output logic [1:0] digit_cnt,
  output logic [2:0] state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DONE_MAX = DW'(DONE_CYCLES - 1);
  localparam logic [1:0]    DIG_MAX  = 2'(MAX_DIGITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENTRY  = 3'd1,
    S_COOK   = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        r_state;
  logic [3:0]    r_data;
  logic          r_loadn;
  logic          r_tclrn;
  logic          r_en;
  logic          r_mag;
  logic          r_done;
  logic [1:0]    r_dcnt;
  logic [PW-1:0] r_pre;
  logic [DW-1:0] r_dcyc;

  state_t        w_state;
  logic [3:0]    w_data;
  logic          w_loadn;
  logic          w_tclrn;
  logic          w_en;
  logic          w_mag;
  logic          w_done;
  logic [1:0]    w_dcnt;
  logic [PW-1:0] w_pre;
  logic [DW-1:0] w_dcyc;

  logic w_key_ok;
  logic w_go;

  // Accepted key: valid BCD digit with room left in the entry.
  always_comb begin
    w_key_ok = key_valid
             && (key_digit <= 4'd9)
             && (r_dcnt < DIG_MAX);
    w_go = start && door_closed;
  end

  // Next-state and next-output decode; every output is registered.
  always_comb begin
    w_state = r_state;
    w_data  = r_data;
    w_loadn = 1'b1;
    w_tclrn = 1'b1;
    w_en    = 1'b0;
    w_mag   = 1'b0;
    w_done  = 1'b0;
    w_dcnt  = r_dcnt;
    w_pre   = r_pre;
    w_dcyc  = '0;

    unique case (r_state)
      S_IDLE: begin
        w_pre = '0;
        if (w_key_ok) begin
          w_data  = key_digit;
          w_loadn = 1'b0;
          w_dcnt  = r_dcnt + 2'd1;
          w_state = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (stop) begin
          w_state = S_IDLE;
          w_tclrn = 1'b0;
          w_dcnt  = '0;
          w_pre   = '0;
        end else if (w_go) begin
          w_state = S_COOK;
          w_mag   = 1'b1;
        end else if (!start && w_key_ok) begin
          w_data  = key_digit;
          w_loadn = 1'b0;
          w_dcnt  = r_dcnt + 2'd1;
        end
      end

      S_COOK: begin
        if (timer_zero) begin
          w_state = S_DONE;
          w_done  = 1'b1;
        end else if (!door_closed || stop) begin
          w_state = S_PAUSED;
        end else begin
          w_mag = 1'b1;
          if (r_pre == PRE_MAX) begin
            w_en  = 1'b1;
            w_pre = '0;
          end else begin
            w_pre = r_pre + 1'b1;
          end
        end
      end

      S_PAUSED: begin
        if (stop) begin
          w_state = S_IDLE;
          w_tclrn = 1'b0;
          w_dcnt  = '0;
          w_pre   = '0;
        end else if (w_go) begin
          w_state = S_COOK;
          w_mag   = 1'b1;
        end
      end

      S_DONE: begin
        if (stop || (r_dcyc == DONE_MAX)) begin
          w_state = S_IDLE;
          w_tclrn = 1'b0;
          w_dcnt  = '0;
          w_pre   = '0;
        end else begin
          w_done = 1'b1;
          w_dcyc = r_dcyc + 1'b1;
        end
      end

      default: begin
        w_state = S_IDLE;
        w_tclrn = 1'b0;
        w_dcnt  = '0;
        w_pre   = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_loadn <= 1'b1;
      r_tclrn <= 1'b0;
      r_en    <= 1'b0;
      r_mag   <= 1'b0;
      r_done  <= 1'b0;
      r_dcnt  <= '0;
      r_pre   <= '0;
      r_dcyc  <= '0;
    end else begin
      r_state <= w_state;
      r_data  <= w_data;
      r_loadn <= w_loadn;
      r_tclrn <= w_tclrn;
      r_en    <= w_en;
      r_mag   <= w_mag;
      r_done  <= w_done;
      r_dcnt  <= w_dcnt;
      r_pre   <= w_pre;
      r_dcyc  <= w_dcyc;
    end
  end

  // Registered outputs straight to the ports.
  always_comb begin
    timer_data  = r_data;
    timer_loadn = r_loadn;
    timer_clrn  = r_tclrn;
    timer_en    = r_en;
    mag_on      = r_mag;
    done        = r_done;
    digit_cnt   = r_dcnt;
    state       = r_state;
  end

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed bench for microwave_ctrl with TICK_DIV=4, DONE_CYCLES=8.
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_microwave_ctrl;

  logic       clk = 1'b0;
  logic       clrn;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic       timer_zero;
  logic [3:0] timer_data;
  logic       timer_loadn;
  logic       timer_clrn;
  logic       timer_en;
  logic       mag_on;
  logic       done;
  logic [1:0] digit_cnt;
  logic [2:0] state;

  int n_chk = 0;
  int n_err = 0;

  microwave_ctrl #(
    .TICK_DIV(4),
    .MAX_DIGITS(3),
    .DONE_CYCLES(8)
  ) dut (
    .clk(clk),
    .clrn(clrn),
    .key_valid(key_valid),
    .key_digit(key_digit),
    .start(start),
    .stop(stop),
    .door_closed(door_closed),
    .timer_zero(timer_zero),
    .timer_data(timer_data),
    .timer_loadn(timer_loadn),
    .timer_clrn(timer_clrn),
    .timer_en(timer_en),
    .mag_on(mag_on),
    .done(done),
    .digit_cnt(digit_cnt),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clrn        = 1'b0;
    key_valid   = 1'b0;
    key_digit   = 4'd0;
    start       = 1'b0;
    stop        = 1'b0;
    door_closed = 1'b1;
    timer_zero  = 1'b0;
    cyc();
    cyc();
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_loadn", 8'(timer_loadn), 8'd1);
    chk("rst_tclrn", 8'(timer_clrn), 8'd0);
    chk("rst_mag", 8'(mag_on), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_en", 8'(timer_en), 8'd0);
    chk("rst_dcnt", 8'(digit_cnt), 8'd0);
    chk("rst_data", 8'(timer_data), 8'd0);
    clrn = 1'b1;
    cyc();
    chk("rel_tclrn", 8'(timer_clrn), 8'd1);

    // Three digits, then one too many.
    key_valid = 1'b1;
    key_digit = 4'd9;
    cyc();
    chk("k9_loadn", 8'(timer_loadn), 8'd0);
    chk("k9_data", 8'(timer_data), 8'd9);
    chk("k9_dcnt", 8'(digit_cnt), 8'd1);
    chk("k9_state", 8'(state), 8'd1);
    key_digit = 4'd3;
    cyc();
    chk("k3_loadn", 8'(timer_loadn), 8'd0);
    chk("k3_data", 8'(timer_data), 8'd3);
    chk("k3_dcnt", 8'(digit_cnt), 8'd2);
    key_digit = 4'd2;
    cyc();
    chk("k2_data", 8'(timer_data), 8'd2);
    chk("k2_dcnt", 8'(digit_cnt), 8'd3);
    key_digit = 4'd5;
    cyc();
    chk("k5_loadn", 8'(timer_loadn), 8'd1);
    chk("k5_dcnt", 8'(digit_cnt), 8'd3);
    chk("k5_data", 8'(timer_data), 8'd2);
    key_valid = 1'b0;
    cyc();
    chk("idle_loadn", 8'(timer_loadn), 8'd1);

    // Start with the door open is ignored.
    door_closed = 1'b0;
    start = 1'b1;
    cyc();
    chk("open_state", 8'(state), 8'd1);
    chk("open_mag", 8'(mag_on), 8'd0);
    start = 1'b0;
    door_closed = 1'b1;

    // Fresh cook: ticks on the 4th, 8th and 12th edge after start.
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("ck_state", 8'(state), 8'd2);
    chk("ck_mag", 8'(mag_on), 8'd1);
    chk("ck_en0", 8'(timer_en), 8'd0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("ck_en%0d", k), 8'(timer_en),
          ((k % 4) == 0) ? 8'd1 : 8'd0);
    end
    cyc();
    cyc();

    // Door opens: pause with the prescaler holding 2.
    door_closed = 1'b0;
    cyc();
    chk("dp_state", 8'(state), 8'd3);
    chk("dp_mag", 8'(mag_on), 8'd0);
    chk("dp_en", 8'(timer_en), 8'd0);
    cyc();
    chk("dp_hold", 8'(state), 8'd3);
    door_closed = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("rs_state", 8'(state), 8'd2);
    chk("rs_mag", 8'(mag_on), 8'd1);
    chk("rs_en0", 8'(timer_en), 8'd0);
    cyc();
    chk("rs_en1", 8'(timer_en), 8'd0);
    cyc();
    chk("rs_en2", 8'(timer_en), 8'd1);

    // Timer hits zero: eight done cycles then clear to idle.
    timer_zero = 1'b1;
    cyc();
    timer_zero = 1'b0;
    chk("dn_state", 8'(state), 8'd4);
    chk("dn_mag", 8'(mag_on), 8'd0);
    chk("dn_en", 8'(timer_en), 8'd0);
    chk("dn_done1", 8'(done), 8'd1);
    for (int k = 2; k <= 8; k++) begin
      cyc();
      chk($sformatf("dn_done%0d", k), 8'(done), 8'd1);
    end
    cyc();
    chk("dx_state", 8'(state), 8'd0);
    chk("dx_done", 8'(done), 8'd0);
    chk("dx_tclrn", 8'(timer_clrn), 8'd0);
    chk("dx_dcnt", 8'(digit_cnt), 8'd0);
    cyc();
    chk("dx_tclrn1", 8'(timer_clrn), 8'd1);

    // Idle ignores start; non-BCD key ignored; start+stop -> idle.
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("is_state", 8'(state), 8'd0);
    key_valid = 1'b1;
    key_digit = 4'hA;
    cyc();
    chk("ka_loadn", 8'(timer_loadn), 8'd1);
    chk("ka_state", 8'(state), 8'd0);
    key_digit = 4'd1;
    cyc();
    key_valid = 1'b0;
    chk("k1_loadn", 8'(timer_loadn), 8'd0);
    chk("k1_state", 8'(state), 8'd1);
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    chk("ss_state", 8'(state), 8'd0);
    chk("ss_tclrn", 8'(timer_clrn), 8'd0);
    chk("ss_dcnt", 8'(digit_cnt), 8'd0);

    // Stop in cook pauses; stop in pause cancels.
    key_valid = 1'b1;
    key_digit = 4'd5;
    cyc();
    key_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("c2_state", 8'(state), 8'd2);
    cyc();
    stop = 1'b1;
    cyc();
    chk("sp_state", 8'(state), 8'd3);
    chk("sp_mag", 8'(mag_on), 8'd0);
    cyc();
    stop = 1'b0;
    chk("sc_state", 8'(state), 8'd0);
    chk("sc_tclrn", 8'(timer_clrn), 8'd0);
    chk("sc_dcnt", 8'(digit_cnt), 8'd0);

    // Reset during cook.
    key_valid = 1'b1;
    key_digit = 4'd7;
    cyc();
    key_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("c3_mag", 8'(mag_on), 8'd1);
    cyc();
    clrn = 1'b0;
    cyc();
    chk("mr_state", 8'(state), 8'd0);
    chk("mr_mag", 8'(mag_on), 8'd0);
    chk("mr_tclrn", 8'(timer_clrn), 8'd0);
    chk("mr_dcnt", 8'(digit_cnt), 8'd0);
    clrn = 1'b1;
    cyc();
    chk("mr_tclrn1", 8'(timer_clrn), 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
